conv_post: RTL

CONV_POST -- requirements
Module: conv_post

---
 rtl/conv_post.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_post.sv
// Conv-core post stage: accumulates CH_NUM signed results, rounds, shifts, clips to 8 bits, and queues them in an FWFT FIFO.
// Optional build macro CONV_POST_RELU_EN: unsigned ReLU clip to [0,255] instead of signed [-128,127].
module conv_post #(
  parameter int CH_NUM     = 3,
  parameter int SHIFT      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [38:0] in_data,
  input  logic        in_valid,
  output logic [7:0]  out_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf_err,
  output logic        busy
);

  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CH_NUM - 1);

  // Round half up: bias by 2^(SHIFT-1), then arithmetic shift. One guard bit keeps the bias from wrapping.
  function automatic logic signed [42:0] round_shift(input logic signed [41:0] a);
    logic signed [42:0] s;
    s = {a[41], a} + (43'sd1 <<< (SHIFT - 1));
    return s >>> SHIFT;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [42:0] v);
`ifdef CONV_POST_RELU_EN
    if (v < 43'sd0)
      return 8'h00;
    else if (v > 43'sd255)
      return 8'hFF;
    else
      return v[7:0];
`else
    if (v > 43'sd127)
      return 8'h7F;
    else if (v < -43'sd128)
      return 8'h80;
    else
      return v[7:0];
`endif
  endfunction

  logic [CW-1:0]       r_cnt_p0;
  logic signed [41:0]  r_acc_p0;
  logic                r_vld_p1;
  logic signed [41:0]  w_ext;
  logic [7:0]          w_pix_p1;

  assign w_ext = {{3{in_data[38]}}, in_data};

  // Stage 0: channel count and accumulation; the final beat raises the done flag for stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_p0 <= '0;
      r_acc_p0 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid && (r_cnt_p0 == LAST);
      if (in_valid) begin
        r_cnt_p0 <= (r_cnt_p0 == LAST) ? '0 : r_cnt_p0 + CW'(1);
        r_acc_p0 <= (r_cnt_p0 == '0) ? w_ext : r_acc_p0 + w_ext;
      end
    end
  end

  // Stage 1: requantize the completed sum; it is pushed into the FIFO at the next edge.
  assign w_pix_p1 = sat8(round_shift(r_acc_p0));

  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = out_ready && !w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push  = r_vld_p1 && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push)
        r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)
        r_rd <= r_rd + (AW+1)'(1);
      if (r_vld_p1 && !w_push)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= w_pix_p1;
  end

  assign out_valid = !w_empty;
  assign out_pix   = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign ovf_err   = r_ovf;
  assign busy      = (r_cnt_p0 != '0) || r_vld_p1;

endmodule
